// File: rtl/adder_rr_scheduler_if.sv
// Request/response bundle shared by the round-robin adder scheduler and its clients.
// Requester i drives req_a/req_b bits [i*WIDTH +: WIDTH].
interface adder_rr_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Single shared WIDTH-bit adder time-multiplexed across four requesters with
// round-robin arbitration: IDLE (grant) -> COMPUTE (add) -> RESP (handshake).
module adder_rr_scheduler #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_rr_scheduler_if.slave  bus,
  output logic                 busy,
  output logic [15:0]          done_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr;
  logic [WIDTH-1:0] op_a, op_b;
  logic [1:0]       op_id;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [1:0]       id_q;

  logic [NREQ-1:0]  gnt;
  logic [1:0]       gidx;
  logic [1:0]       idx;
  logic             found;
  logic             accept;
  logic             rsp_fire;

  // Search upward from ptr, wrapping 3 -> 0; first valid requester wins.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    if (state == IDLE && !rst) begin
      for (int unsigned k = 0; k < 4; k++) begin
        idx = ptr + 2'(k);
        if (!found && bus.req_valid[idx]) begin
          found = 1'b1;
          gidx  = idx;
        end
      end
    end
    if (found) gnt[gidx] = 1'b1;
  end

  assign accept   = found;
  assign rsp_fire = (state == RESP) && bus.rsp_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = COMPUTE;
      COMPUTE:               state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operands are captured at acceptance so later input changes cannot disturb
  // the operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      op_id <= '0;
    end else if (state == IDLE && accept) begin
      op_a  <= bus.req_a[gidx*WIDTH +: WIDTH];
      op_b  <= bus.req_b[gidx*WIDTH +: WIDTH];
      op_id <= gidx;
    end
  end

  // The one shared adder; results hold through RESP until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
    end else if (state == COMPUTE) begin
      {carry_q, sum_q} <= {1'b0, op_a} + {1'b0, op_b};
      id_q             <= op_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      done_cnt <= '0;
    end else if (rsp_fire) begin
      ptr      <= id_q + 2'd1;
      done_cnt <= done_cnt + 16'd1;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_carry = carry_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: reset, single ops, overflow,
// round-robin order/throughput, back-pressure and reset mid-operation.
module tb_adder_rr_scheduler;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] done_cnt;
  int          total;
  int          bad;

  adder_rr_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  adder_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    #3;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done_cnt !== 16'd0) begin bad++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    total++; if ({bus.rsp_id, bus.rsp_sum, bus.rsp_carry} !== 11'd0) begin bad++; $display("FAIL reset_rsp_fields got=%h exp=0", {bus.rsp_id, bus.rsp_sum, bus.rsp_carry}); end
    tick();
    tick();
    bus.req_valid = 4'h0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus.req_valid = 4'b0001;
    set_op(0, 8'd10, 8'd5);
    bus.rsp_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", bus.req_ready); end
    tick();
    // operands and valid change after acceptance; result must be unaffected
    bus.req_valid = 4'b0000;
    set_op(0, 8'd77, 8'd99);
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_valid_early got=%b exp=0", bus.rsp_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_compute got=%b exp=0000", bus.req_ready); end
    tick();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL single_id got=%0d exp=0", bus.rsp_id); end
    total++; if (bus.rsp_sum !== 8'd15) begin bad++; $display("FAIL single_sum got=%0d exp=15", bus.rsp_sum); end
    total++; if (bus.rsp_carry !== 1'b0) begin bad++; $display("FAIL single_carry got=%b exp=0", bus.rsp_carry); end
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_valid_after got=%b exp=0", bus.rsp_valid); end
    total++; if (done_cnt !== 16'd1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask

  task automatic test_overflow();
    // pointer is 1 here; requester 2 is the only one valid
    bus.req_valid = 4'b0100;
    set_op(2, 8'd255, 8'd1);
    #1;
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL ovf2_grant got=%b exp=0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    tick();
    total++; if ({bus.rsp_id, bus.rsp_carry, bus.rsp_sum} !== {2'd2, 1'b1, 8'd0}) begin bad++; $display("FAIL ovf2_result got id=%0d c=%b s=%0d exp id=2 c=1 s=0", bus.rsp_id, bus.rsp_carry, bus.rsp_sum); end
    tick();
    bus.req_valid = 4'b1000;
    set_op(3, 8'd128, 8'd128);
    #1;
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL ovf3_grant got=%b exp=1000", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    tick();
    total++; if ({bus.rsp_id, bus.rsp_carry, bus.rsp_sum} !== {2'd3, 1'b1, 8'd0}) begin bad++; $display("FAIL ovf3_result got id=%0d c=%b s=%0d exp id=3 c=1 s=0", bus.rsp_id, bus.rsp_carry, bus.rsp_sum); end
    tick();
    total++; if (done_cnt !== 16'd3) begin bad++; $display("FAIL ovf_done_cnt got=%0d exp=3", done_cnt); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5];
    logic [7:0] exp_sum [4];
    logic [3:0] exp_next [5];
    int n;
    int last_cyc;
    exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_sum  = '{8'd4, 8'd21, 8'd38, 8'd55};
    exp_next = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    for (int i = 0; i < 4; i++) set_op(i, 8'(16*i + 3), 8'(i + 1));
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rr_first_grant got=%b exp=0001", bus.req_ready); end
    n = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 40 && n < 5; cyc++) begin
      tick();
      if (bus.rsp_valid === 1'b1) begin
        total++; if (bus.rsp_id !== exp_id[n]) begin bad++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", n, bus.rsp_id, exp_id[n]); end
        total++; if (bus.rsp_sum !== exp_sum[exp_id[n]]) begin bad++; $display("FAIL rr_sum[%0d] got=%0d exp=%0d", n, bus.rsp_sum, exp_sum[exp_id[n]]); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rr_ready_in_resp[%0d] got=%b exp=0000", n, bus.req_ready); end
        if (n > 0) begin
          total++; if (cyc - last_cyc !== 3) begin bad++; $display("FAIL rr_spacing[%0d] got=%0d exp=3", n, cyc - last_cyc); end
        end
        last_cyc = cyc;
        if (n == 4) bus.req_valid = 4'b0000;
        tick();
        cyc++;
        // handshake cycle accepted nothing; the next grant shows only now
        total++; if (bus.req_ready !== exp_next[n]) begin bad++; $display("FAIL rr_next_grant[%0d] got=%b exp=%b", n, bus.req_ready, exp_next[n]); end
        n++;
      end
    end
    total++; if (n !== 5) begin bad++; $display("FAIL rr_count got=%0d exp=5", n); end
    total++; if (done_cnt !== 16'd8) begin bad++; $display("FAIL rr_done_cnt got=%0d exp=8", done_cnt); end
  endtask

  task automatic test_backpressure();
    // pointer is 1: 200 + 100 = 300 -> sum 44, carry 1
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    set_op(1, 8'd200, 8'd100);
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant got=%b exp=0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_sum} !== {1'b1, 2'd1, 1'b1, 8'd44}) begin bad++; $display("FAIL bp_hold[%0d] got v=%b id=%0d c=%b s=%0d exp v=1 id=1 c=1 s=44", k, bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_sum); end
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, bus.req_ready); end
      total++; if (done_cnt !== 16'd8) begin bad++; $display("FAIL bp_done_cnt[%0d] got=%0d exp=8", k, done_cnt); end
      tick();
    end
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    #1;
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_before got=%b exp=1", bus.rsp_valid); end
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_after got=%b exp=0", bus.rsp_valid); end
    total++; if (done_cnt !== 16'd9) begin bad++; $display("FAIL bp_done_after got=%0d exp=9", done_cnt); end
  endtask

  task automatic test_reset_in_flight();
    bus.req_valid = 4'b0100;
    set_op(2, 8'd1, 8'd2);
    tick();
    bus.req_valid = 4'b0000;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rif_busy_compute got=%b exp=1", busy); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rif_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rif_busy got=%b exp=0", busy); end
    total++; if (done_cnt !== 16'd0) begin bad++; $display("FAIL rif_done_cnt got=%0d exp=0", done_cnt); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rif_no_stray_rsp got=%b exp=0", bus.rsp_valid); end
    bus.req_valid = 4'b1010;
    set_op(1, 8'd7, 8'd9);
    set_op(3, 8'd50, 8'd60);
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL rif_grant got=%b exp=0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    tick();
    total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_sum} !== {1'b1, 2'd1, 1'b0, 8'd16}) begin bad++; $display("FAIL rif_result got v=%b id=%0d c=%b s=%0d exp v=1 id=1 c=0 s=16", bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_sum); end
    tick();
    total++; if (done_cnt !== 16'd1) begin bad++; $display("FAIL rif_done_after got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
